// File: rtl/pitch_glide_control.sv
// Per-voice pitch engine: key tracking with optional portamento, coarse/fine/bend offsets, saturated output.
// Optional glide (portamento) logic is built only when PITCH_GLIDE_EN is defined.
//
// state    | meaning
// ---------+--------------------------------------------------
// ST_IDLE  | cur has reached target; no glide steps applied
// ST_GLIDE | cur steps toward target by glide_rate[0] per osc-0 slot
module pitch_glide_control #(
    parameter int VOICES  = 8,
    parameter int V_OSC   = 4,
    parameter int V_WIDTH = 3,
    parameter int O_WIDTH = 2,
    parameter int PW      = 16
) (
    input  logic                       sCLK_XVXOSC,
    input  logic                       reset_reg_N,
    input  logic [V_WIDTH+O_WIDTH-1:0] slot,
    input  logic                       slot_valid,
    input  logic                       key_wr,
    input  logic [V_WIDTH-1:0]         key_adr,
    input  logic [7:0]                 key_val,
    input  logic [13:0]                pitch_val,
    input  logic [3:0]                 pb_range,
    input  logic                       cfg_we,
    input  logic [O_WIDTH-1:0]         cfg_osc,
    input  logic [1:0]                 cfg_sel,
    input  logic [7:0]                 cfg_data,
    output logic [PW-1:0]              pitch_out,
    output logic                       pitch_valid,
    output logic [V_WIDTH+O_WIDTH-1:0] pitch_slot
);

    localparam int SW  = PW + 3;
    localparam int SLW = V_WIDTH + O_WIDTH;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_GLIDE = 1'b1;

    logic [7:0]         coarse [V_OSC];
    logic [7:0]         fine   [V_OSC];

    logic [PW-1:0]      tgt     [VOICES];
    logic [PW-1:0]      cur     [VOICES];
    logic [PW-1:0]      tgt_nxt [VOICES];
    logic [PW-1:0]      cur_nxt [VOICES];
    logic [VOICES-1:0]  seen;
    logic [VOICES-1:0]  seen_nxt;

    logic [V_WIDTH-1:0] slot_voice;
    logic [O_WIDTH-1:0] slot_osc;
    logic [PW-1:0]      key_tgt;

    assign slot_voice = slot[SLW-1:O_WIDTH];
    assign slot_osc   = slot[O_WIDTH-1:0];
    assign key_tgt    = PW'({key_val[6:0], 6'b000000});

    always_ff @(posedge sCLK_XVXOSC or negedge reset_reg_N) begin
        if (!reset_reg_N) begin
            for (int o = 0; o < V_OSC; o++) begin
                coarse[o] <= 8'd64;
                fine[o]   <= 8'd64;
            end
        end else if (cfg_we) begin
            case (cfg_sel)
                2'd0:    coarse[cfg_osc] <= cfg_data;
                2'd1:    fine[cfg_osc]   <= cfg_data;
                default: ;
            endcase
        end
    end

`ifdef PITCH_GLIDE_EN
    logic [7:0]         glide_rate [V_OSC];
    logic [VOICES-1:0]  st;
    logic [VOICES-1:0]  st_nxt;
    logic [PW-1:0]      rate_ext;
    logic               g_up;
    logic [PW-1:0]      g_dist;
    logic               g_hit;

    always_ff @(posedge sCLK_XVXOSC or negedge reset_reg_N) begin
        if (!reset_reg_N) begin
            for (int o = 0; o < V_OSC; o++) begin
                glide_rate[o] <= 8'd0;
            end
        end else if (cfg_we && cfg_sel == 2'd2) begin
            glide_rate[cfg_osc] <= cfg_data;
        end
    end

    // Only oscillator 0 of a voice advances the glide, so each voice steps once per scan.
    assign rate_ext = PW'(glide_rate[0]);
    assign g_up     = tgt[slot_voice] >= cur[slot_voice];
    assign g_dist   = g_up ? (tgt[slot_voice] - cur[slot_voice])
                           : (cur[slot_voice] - tgt[slot_voice]);
    assign g_hit    = slot_valid && (slot_osc == '0) && (st[slot_voice] == ST_GLIDE);
`endif

    always_comb begin
        for (int v = 0; v < VOICES; v++) begin
            tgt_nxt[v] = tgt[v];
            cur_nxt[v] = cur[v];
        end
        seen_nxt = seen;
`ifdef PITCH_GLIDE_EN
        st_nxt = st;
        if (g_hit) begin
            if (g_dist <= rate_ext) begin
                cur_nxt[slot_voice] = tgt[slot_voice];
                st_nxt[slot_voice]  = ST_IDLE;
            end else if (g_up) begin
                cur_nxt[slot_voice] = cur[slot_voice] + rate_ext;
            end else begin
                cur_nxt[slot_voice] = cur[slot_voice] - rate_ext;
            end
        end
`endif
        // A key event overrides any glide step on the same voice this cycle.
        if (key_wr && !key_val[7]) begin
            tgt_nxt[key_adr]  = key_tgt;
            seen_nxt[key_adr] = 1'b1;
`ifdef PITCH_GLIDE_EN
            if (!seen[key_adr] || glide_rate[0] == 8'd0) begin
                cur_nxt[key_adr] = key_tgt;
                st_nxt[key_adr]  = ST_IDLE;
            end else begin
                cur_nxt[key_adr] = cur[key_adr];
                st_nxt[key_adr]  = ST_GLIDE;
            end
`else
            cur_nxt[key_adr] = key_tgt;
`endif
        end
    end

    always_ff @(posedge sCLK_XVXOSC or negedge reset_reg_N) begin
        if (!reset_reg_N) begin
            for (int v = 0; v < VOICES; v++) begin
                tgt[v] <= '0;
                cur[v] <= '0;
            end
            seen <= '0;
`ifdef PITCH_GLIDE_EN
            st   <= '0;
`endif
        end else begin
            for (int v = 0; v < VOICES; v++) begin
                tgt[v] <= tgt_nxt[v];
                cur[v] <= cur_nxt[v];
            end
            seen <= seen_nxt;
`ifdef PITCH_GLIDE_EN
            st   <= st_nxt;
`endif
        end
    end

    // Stage 1: capture operands, using cur as it stands after this cycle's update.
    logic           s1_vld;
    logic [SLW-1:0] s1_slot;
    logic [PW-1:0]  s1_cur;
    logic [7:0]     s1_coarse;
    logic [7:0]     s1_fine;
    logic [13:0]    s1_pv;
    logic [3:0]     s1_pr;

    always_ff @(posedge sCLK_XVXOSC or negedge reset_reg_N) begin
        if (!reset_reg_N) begin
            s1_vld    <= 1'b0;
            s1_slot   <= '0;
            s1_cur    <= '0;
            s1_coarse <= 8'd64;
            s1_fine   <= 8'd64;
            s1_pv     <= 14'h2000;
            s1_pr     <= '0;
        end else begin
            s1_vld <= slot_valid;
            if (slot_valid) begin
                s1_slot   <= slot;
                s1_cur    <= cur_nxt[slot_voice];
                s1_coarse <= coarse[slot_osc];
                s1_fine   <= fine[slot_osc];
                s1_pv     <= pitch_val;
                s1_pr     <= pb_range;
            end
        end
    end

    logic signed [8:0]    c_diff;
    logic signed [8:0]    f_diff;
    logic signed [14:0]   p_diff;
    logic signed [19:0]   b_prod;
    logic signed [SW-1:0] sum;

    assign c_diff = $signed({1'b0, s1_coarse}) - 9'sd64;
    assign f_diff = $signed({1'b0, s1_fine}) - 9'sd64;
    assign p_diff = $signed({1'b0, s1_pv}) - 15'sd8192;
    assign b_prod = 20'(p_diff) * 20'($signed({1'b0, s1_pr}));
    assign sum    = SW'($signed({1'b0, s1_cur}))
                  + (SW'(c_diff) <<< 6)
                  + SW'(f_diff)
                  + SW'(b_prod >>> 7);

    // Stage 2: hold the raw signed sum; clamp on the way to the output register.
    logic                 s2_vld;
    logic [SLW-1:0]       s2_slot;
    logic signed [SW-1:0] s2_sum;
    logic [PW-1:0]        sat;

    always_ff @(posedge sCLK_XVXOSC or negedge reset_reg_N) begin
        if (!reset_reg_N) begin
            s2_vld  <= 1'b0;
            s2_slot <= '0;
            s2_sum  <= '0;
        end else begin
            s2_vld  <= s1_vld;
            s2_slot <= s1_slot;
            s2_sum  <= sum;
        end
    end

    always_comb begin
        sat = s2_sum[PW-1:0];
        if (s2_sum[SW-1]) begin
            sat = '0;
        end else if (s2_sum[SW-2:PW] != '0) begin
            sat = '1;
        end
    end

    always_ff @(posedge sCLK_XVXOSC or negedge reset_reg_N) begin
        if (!reset_reg_N) begin
            pitch_out   <= '0;
            pitch_valid <= 1'b0;
            pitch_slot  <= '0;
        end else begin
            pitch_valid <= s2_vld;
            if (s2_vld) begin
                pitch_out  <= sat;
                pitch_slot <= s2_slot;
            end
        end
    end

endmodule
